// File: rtl/serial_diff_pkg.sv
// Shared encodings for the bit-serial add/subtract sequencer.
package serial_diff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_diff_ctrl_if.sv
// Request/result bundle for serial_diff_ctrl.
// Optional macro SERIAL_DIFF_OVF_EN adds the signed-overflow flag ovf.
interface serial_diff_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
`ifdef SERIAL_DIFF_OVF_EN
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  ready, busy, done, result, carry, ovf
  );
  modport slave (
    input  start, sub, a, b,
    output ready, busy, done, result, carry, ovf
  );
`else
  modport master (
    output start, sub, a, b,
    input  ready, busy, done, result, carry
  );
  modport slave (
    input  start, sub, a, b,
    output ready, busy, done, result, carry
  );
`endif
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by all bit-cycles of the sequencer.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Pure combinational sum/carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_diff_ctrl.sv
// Bit-serial add/subtract sequencer: one full_adder cell is stepped over WIDTH cycles,
// LSB first. Subtraction is a + ~b + 1 (carry-in preset to 1).
// Optional macro SERIAL_DIFF_OVF_EN adds a registered signed-overflow flag.
module serial_diff_ctrl
  import serial_diff_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_diff_ctrl_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_q;
  logic             c_q;
  logic [CntW-1:0]  cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
`ifdef SERIAL_DIFF_OVF_EN
  logic             ovf_q;
`endif

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] acc_next;

  full_adder u_full_adder (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Accumulator after this bit-cycle: new sum bit enters at the MSB.
  always_comb begin
    acc_next = {fa_sum, acc_q[WIDTH-1:1]};
  end

  // Control FSM, operand shifters, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
`ifdef SERIAL_DIFF_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            // Accept: result/carry stay held until this op completes.
            a_sh_q  <= bus.a;
            b_sh_q  <= (bus.sub == OP_SUB) ? ~bus.b : bus.b;
            c_q     <= bus.sub;
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef SERIAL_DIFF_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          acc_q  <= acc_next;
          c_q    <= fa_cout;
          if (cnt_q == CntLast) begin
            result_q <= acc_next;
            carry_q  <= fa_cout;
`ifdef SERIAL_DIFF_OVF_EN
            // Carry into MSB differs from carry out of MSB.
            ovf_q    <= c_q ^ fa_cout;
`endif
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are driven straight from registers.
  always_comb begin
    bus.ready  = ready_q;
    bus.busy   = busy_q;
    bus.done   = done_q;
    bus.result = result_q;
    bus.carry  = carry_q;
`ifdef SERIAL_DIFF_OVF_EN
    bus.ovf    = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_diff_ctrl.sv
// Directed bench for serial_diff_ctrl (WIDTH=8). Overflow checks are built only when
// SERIAL_DIFF_OVF_EN is defined.
module tb_serial_diff_ctrl;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  serial_diff_ctrl_if #(.WIDTH(W)) bus ();

  serial_diff_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done; lat counts rising edges since start was driven.
  task automatic wait_done(inout int lat);
    while (bus.done !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input logic s, input logic [7:0] x, input logic [7:0] y,
                       output int lat);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.a     = x;
    bus.b     = y;
    tick();
    bus.start = 1'b0;
    lat = 1;
    wait_done(lat);
  endtask

  int lat;
  int done_seen;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_carry", bus.carry, 0);
`ifdef SERIAL_DIFF_OVF_EN
    check("rst_ovf", bus.ovf, 0);
`endif

    // 100 - 37
    do_op(1'b1, 8'd100, 8'd37, lat);
    check("sub1_latency", lat, W + 1);
    check("sub1_result", bus.result, 63);
    check("sub1_carry", bus.carry, 1);
    check("sub1_ready", bus.ready, 1);
    tick();
    check("done_one_cycle", bus.done, 0);

    // 5 - 10 borrows
    do_op(1'b1, 8'd5, 8'd10, lat);
    check("sub2_result", bus.result, 251);
    check("sub2_carry", bus.carry, 0);
    tick();

    // 200 + 100 wraps
    do_op(1'b0, 8'd200, 8'd100, lat);
    check("add1_latency", lat, W + 1);
    check("add1_result", bus.result, 44);
    check("add1_carry", bus.carry, 1);
    tick();

    // start during SHIFT is ignored
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.a     = 8'd10;
    bus.b     = 8'd20;
    tick();
    check("busy_after_accept", bus.busy, 1);
    check("ready_after_accept", bus.ready, 0);
    check("result_held", bus.result, 44);
    bus.sub = 1'b1;
    bus.a   = 8'd99;
    bus.b   = 8'd3;
    tick();
    tick();
    bus.start = 1'b0;
    lat = 3;
    wait_done(lat);
    check("ignore_latency", lat, W + 1);
    check("ignore_result", bus.result, 30);
    check("ignore_carry", bus.carry, 0);

    // back-to-back from DONE: 1 + 2
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.a     = 8'd1;
    bus.b     = 8'd2;
    tick();
    bus.start = 1'b0;
    check("b2b_busy", bus.busy, 1);
    check("b2b_ready", bus.ready, 0);
    lat = 1;
    wait_done(lat);
    check("b2b_latency", lat, W + 1);
    check("b2b_result", bus.result, 3);
    tick();

    // reset at bit-cycle 4 aborts
    bus.start = 1'b1;
    bus.sub   = 1'b1;
    bus.a     = 8'd200;
    bus.b     = 8'd1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", bus.ready, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_result", bus.result, 0);
    check("abort_carry", bus.carry, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) done_seen++;
      tick();
    end
    check("abort_no_done", done_seen, 0);

`ifdef SERIAL_DIFF_OVF_EN
    do_op(1'b0, 8'd127, 8'd1, lat);
    check("ovf_add_result", bus.result, 128);
    check("ovf_add_flag", bus.ovf, 1);
    tick();
    do_op(1'b1, 8'd128, 8'd1, lat);
    check("ovf_sub_result", bus.result, 127);
    check("ovf_sub_flag", bus.ovf, 1);
    tick();
    do_op(1'b1, 8'd3, 8'd1, lat);
    check("noovf_result", bus.result, 2);
    check("noovf_flag", bus.ovf, 0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
